// File: rtl/roce_stack_pkg.sv
// rtl/roce_stack_pkg.sv - shared types and constants for the RoCE address translator
package roce_stack_pkg;

  localparam int VADDR_W = 64;
  localparam int PADDR_W = 64;
  localparam int LEN_W   = 48;
  localparam int ACC_W   = 4;

  // Access descriptor bits; all-zero means no access granted
  localparam logic [ACC_W-1:0] ACC_NONE          = 4'h0;
  localparam logic [ACC_W-1:0] ACC_LOCAL_WR      = 4'h1;
  localparam logic [ACC_W-1:0] ACC_REMOTE_RD     = 4'h2;
  localparam logic [ACC_W-1:0] ACC_REMOTE_WR     = 4'h4;
  localparam logic [ACC_W-1:0] ACC_REMOTE_ATOMIC = 4'h8;

  // Translation response, paddr in the least significant bits (116 bits)
  typedef struct packed {
    logic [ACC_W-1:0]   access;
    logic [LEN_W-1:0]   buflen;
    logic [PADDR_W-1:0] paddr;
  } xlat_resp_t;

  // One translation table entry (180 bits); the valid bit lives beside it
  typedef struct packed {
    logic [VADDR_W-1:0] vaddr;
    logic [PADDR_W-1:0] paddr;
    logic [LEN_W-1:0]   len;
    logic [ACC_W-1:0]   access;
  } xlat_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } xlat_state_t;

  // Increment that sticks at all-ones
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/roce_stack_xlat_match.sv
// rtl/roce_stack_xlat_match.sv - range compare of one lookup address against one table entry
module roce_stack_xlat_match
  import roce_stack_pkg::*;
(
  input  logic               valid_i,
  input  xlat_entry_t        entry_i,
  input  logic [VADDR_W-1:0] vaddr_i,
  output logic               hit_o,
  output logic [VADDR_W-1:0] offset_o
);

  // End address kept one bit wider so a region touching the top of memory never wraps
  logic [VADDR_W:0] end_addr;

  assign end_addr = {1'b0, entry_i.vaddr} + {{(VADDR_W + 1 - LEN_W){1'b0}}, entry_i.len};

  assign hit_o = valid_i
              && (entry_i.len != '0)
              && (vaddr_i >= entry_i.vaddr)
              && ({1'b0, vaddr_i} < end_addr);

  assign offset_o = vaddr_i - entry_i.vaddr;

endmodule

// File: rtl/roce_stack_addr_translator.sv
// rtl/roce_stack_addr_translator.sv - flop-based virtual-to-physical translation table with lookup FSM
module roce_stack_addr_translator
  import roce_stack_pkg::*;
#(
  parameter int NUM_ENTRIES = 8
) (
  input  logic                           clk_i,
  input  logic                           aresetn_i,
  input  logic                           req_addr_valid_i,
  output logic                           req_addr_ready_o,
  input  logic [63:0]                    req_addr_vaddr_i,
  output logic                           resp_addr_valid_o,
  input  logic                           resp_addr_ready_i,
  output logic [115:0]                   resp_addr_data_o,
  input  logic                           cfg_wr_valid_i,
  output logic                           cfg_wr_ready_o,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx_i,
  input  logic [63:0]                    cfg_vaddr_i,
  input  logic [63:0]                    cfg_paddr_i,
  input  logic [47:0]                    cfg_len_i,
  input  logic [3:0]                     cfg_access_i,
  input  logic                           cfg_en_i,
  input  logic                           flush_i,
  output logic [31:0]                    hit_cnt_o,
  output logic [31:0]                    miss_cnt_o
);

  xlat_state_t              state_q;
  logic [VADDR_W-1:0]       vaddr_q;
  xlat_resp_t               resp_q;
  logic                     resp_valid_q;
  logic [31:0]              hit_cnt_q;
  logic [31:0]              miss_cnt_q;
  logic [NUM_ENTRIES-1:0]   valid_q;
  logic                     flush_pend_q;
  xlat_entry_t              table_q [NUM_ENTRIES];

  logic                     cfg_hs;
  logic                     flush_now;
  logic [NUM_ENTRIES-1:0]   hit_vec;
  logic [VADDR_W-1:0]       offset [NUM_ENTRIES];
  logic                     lookup_hit;
  xlat_resp_t               lookup_resp;

  // Config is locked out during the compare cycle and whenever a flush is applied
  assign cfg_wr_ready_o   = aresetn_i && (state_q != ST_LOOKUP) && !flush_i;
  // A pending cfg write or flush takes priority over a new lookup
  assign req_addr_ready_o = aresetn_i && (state_q == ST_IDLE) && !flush_i && !cfg_wr_valid_i;

  assign cfg_hs    = cfg_wr_valid_i && cfg_wr_ready_o;
  // A flush seen during LOOKUP is deferred so the in-flight compare sees a stable table
  assign flush_now = (flush_i && (state_q != ST_LOOKUP)) || flush_pend_q;

  assign resp_addr_valid_o = resp_valid_q;
  assign resp_addr_data_o  = resp_q;
  assign hit_cnt_o         = hit_cnt_q;
  assign miss_cnt_o        = miss_cnt_q;

  genvar g;
  generate
    for (g = 0; g < NUM_ENTRIES; g++) begin : g_match
      roce_stack_xlat_match u_match (
        .valid_i  (valid_q[g]),
        .entry_i  (table_q[g]),
        .vaddr_i  (vaddr_q),
        .hit_o    (hit_vec[g]),
        .offset_o (offset[g])
      );
    end
  endgenerate

  // Priority select: walk downwards so the lowest hitting index is the last one written
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_resp = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        lookup_hit         = 1'b1;
        lookup_resp.paddr  = table_q[i].paddr + offset[i];
        lookup_resp.buflen = table_q[i].len - offset[i][LEN_W-1:0];
        lookup_resp.access = table_q[i].access;
      end
    end
  end

  // Entry payload storage; liveness is tracked only by valid_q so no reset is needed here
  always_ff @(posedge clk_i) begin
    if (cfg_hs && cfg_en_i) begin
      table_q[cfg_idx_i] <= '{vaddr:  cfg_vaddr_i,
                              paddr:  cfg_paddr_i,
                              len:    cfg_len_i,
                              access: cfg_access_i};
    end
  end

  // Valid bits and deferred flush; a cfg write landing together with a deferred flush survives it
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_i && (state_q == ST_LOOKUP);
      if (flush_now) begin
        valid_q <= '0;
      end
      if (cfg_hs) begin
        valid_q[cfg_idx_i] <= cfg_en_i;
      end
    end
  end

  // Lookup FSM: accept address, compare for one cycle, hold response until taken
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q      <= ST_IDLE;
      vaddr_q      <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_addr_valid_i && req_addr_ready_o) begin
            vaddr_q <= req_addr_vaddr_i;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          resp_q       <= lookup_resp;
          resp_valid_q <= 1'b1;
          if (lookup_hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_q <= sat_inc(miss_cnt_q);
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_addr_ready_i) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roce_stack_addr_translator.sv
// tb/tb_roce_stack_addr_translator.sv - self-checking bench for the address translator
module tb_roce_stack_addr_translator;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         aresetn = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [63:0]  req_vaddr = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [115:0] resp_data;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [2:0]   cfg_idx = '0;
  logic [63:0]  cfg_vaddr = '0;
  logic [63:0]  cfg_paddr = '0;
  logic [47:0]  cfg_len = '0;
  logic [3:0]   cfg_access = '0;
  logic         cfg_en = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int total = 0;
  int bad   = 0;

  // Reference table and statistics
  logic [63:0] m_v   [N];
  logic [63:0] m_p   [N];
  logic [47:0] m_len [N];
  logic [3:0]  m_acc [N];
  logic        m_ok  [N];
  logic [31:0] m_hits = '0;
  logic [31:0] m_miss = '0;

  always #5 clk = ~clk;

  roce_stack_addr_translator #(.NUM_ENTRIES(N)) dut (
    .clk_i             (clk),
    .aresetn_i         (aresetn),
    .req_addr_valid_i  (req_valid),
    .req_addr_ready_o  (req_ready),
    .req_addr_vaddr_i  (req_vaddr),
    .resp_addr_valid_o (resp_valid),
    .resp_addr_ready_i (resp_ready),
    .resp_addr_data_o  (resp_data),
    .cfg_wr_valid_i    (cfg_valid),
    .cfg_wr_ready_o    (cfg_ready),
    .cfg_idx_i         (cfg_idx),
    .cfg_vaddr_i       (cfg_vaddr),
    .cfg_paddr_i       (cfg_paddr),
    .cfg_len_i         (cfg_len),
    .cfg_access_i      (cfg_access),
    .cfg_en_i          (cfg_en),
    .flush_i           (flush),
    .hit_cnt_o         (hit_cnt),
    .miss_cnt_o        (miss_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First entry in index order whose [base, base+len) range holds va, with 65-bit end
  task automatic model_lookup(input logic [63:0] va, output bit hit, output logic [115:0] data);
    logic [64:0] lim;
    logic [63:0] off;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      lim = {1'b0, m_v[i]} + {17'b0, m_len[i]};
      if (!hit && m_ok[i] && m_len[i] != 48'd0 && va >= m_v[i] && {1'b0, va} < lim) begin
        off  = va - m_v[i];
        hit  = 1'b1;
        data = {m_acc[i], m_len[i] - off[47:0], m_p[i] + off};
      end
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < N; i++) m_ok[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    m_hits = '0;
    m_miss = '0;
  endtask

  task automatic cfg_write(input int idx, input logic [63:0] v, input logic [63:0] p,
                           input logic [47:0] len, input logic [3:0] acc, input logic en);
    cfg_valid  = 1'b1;
    cfg_idx    = idx[2:0];
    cfg_vaddr  = v;
    cfg_paddr  = p;
    cfg_len    = len;
    cfg_access = acc;
    cfg_en     = en;
    #1;
    chk("cfg_ready", {127'd0, cfg_ready}, 128'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_ok[idx] = en;
    if (en) begin
      m_v[idx]   = v;
      m_p[idx]   = p;
      m_len[idx] = len;
      m_acc[idx] = acc;
    end
  endtask

  // Handshake the request, then check the response shows up exactly two edges later
  task automatic start_lookup(input logic [63:0] va, input bit flush_mid, output logic [115:0] exp);
    bit hs;
    bit hit;
    int n;
    req_valid = 1'b1;
    req_vaddr = va;
    #1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 20) begin
      hs = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("req_handshake", {127'd0, hs}, 128'd1);
    model_lookup(va, hit, exp);
    if (hit) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      if (m_miss != 32'hFFFF_FFFF) m_miss++;
    end
    chk("lookup_not_early", {127'd0, resp_valid}, 128'd0);
    if (flush_mid) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (flush_mid) model_flush();
    chk("resp_valid", {127'd0, resp_valid}, 128'd1);
    chk("resp_data", {12'd0, resp_data}, {12'd0, exp});
    chk("hit_cnt", {96'd0, hit_cnt}, {96'd0, m_hits});
    chk("miss_cnt", {96'd0, miss_cnt}, {96'd0, m_miss});
  endtask

  task automatic finish_lookup();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_dropped", {127'd0, resp_valid}, 128'd0);
  endtask

  task automatic lookup(input logic [63:0] va, output logic [115:0] got);
    logic [115:0] exp;
    start_lookup(va, 1'b0, exp);
    got = resp_data;
    finish_lookup();
  endtask

  initial begin
    logic [115:0] d;
    logic [115:0] e;
    bit hs;
    int n;
    model_reset();

    // Reset state
    #1 aresetn = 1'b0;
    #1;
    chk("rst_req_ready", {127'd0, req_ready}, 128'd0);
    chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
    chk("rst_resp_data", {12'd0, resp_data}, 128'd0);
    chk("rst_hits", {96'd0, hit_cnt}, 128'd0);
    chk("rst_miss", {96'd0, miss_cnt}, 128'd0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    #1;
    chk("rel_req_ready", {127'd0, req_ready}, 128'd1);
    chk("rel_cfg_ready", {127'd0, cfg_ready}, 128'd1);

    // Basic hit
    cfg_write(0, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3, 1'b1);
    lookup(64'h1800, d);
    chk("basic_hit", {12'd0, d}, {12'd0, 4'h3, 48'h1800, 64'h8000_0800});
    chk("basic_hitcnt", {96'd0, hit_cnt}, 128'd1);

    // Range boundaries
    lookup(64'h3000, d);
    chk("end_bound_miss", {12'd0, d}, 128'd0);
    lookup(64'h0FFF, d);
    chk("low_bound_miss", {12'd0, d}, 128'd0);
    chk("bound_misscnt", {96'd0, miss_cnt}, 128'd2);
    lookup(64'h2FFF, d);
    chk("last_byte_hit", {12'd0, d}, {12'd0, 4'h3, 48'h1, 64'h8000_1FFF});

    // Overlap priority
    cfg_write(1, 64'h4000, 64'hA000, 48'h100, 4'h1, 1'b1);
    cfg_write(5, 64'h3F00, 64'hB000, 48'h1000, 4'h2, 1'b1);
    lookup(64'h4000, d);
    chk("prio_low_idx", {12'd0, d}, {12'd0, 4'h1, 48'h100, 64'hA000});
    cfg_write(1, 64'h0, 64'h0, 48'h0, 4'h0, 1'b0);
    lookup(64'h4000, d);
    chk("prio_after_inval", {12'd0, d}, {12'd0, 4'h2, 48'hF00, 64'hB100});

    // Region at the top of the address space
    cfg_write(2, 64'hFFFF_FFFF_FFFF_F000, 64'h1_0000, 48'h2000, 4'h4, 1'b1);
    lookup(64'hFFFF_FFFF_FFFF_FFF0, d);
    chk("top_hit", {12'd0, d}, {12'd0, 4'h4, 48'h1010, 64'h1_0FF0});
    lookup(64'h0, d);
    chk("no_wrap_miss", {12'd0, d}, 128'd0);

    // cfg write and request in the same IDLE cycle: write first, request one cycle later
    req_valid  = 1'b1;
    req_vaddr  = 64'h6010;
    cfg_valid  = 1'b1;
    cfg_idx    = 3'd6;
    cfg_vaddr  = 64'h6000;
    cfg_paddr  = 64'hC000;
    cfg_len    = 48'h40;
    cfg_access = 4'h5;
    cfg_en     = 1'b1;
    #1;
    chk("collide_req_stall", {127'd0, req_ready}, 128'd0);
    chk("collide_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    m_ok[6] = 1'b1; m_v[6] = 64'h6000; m_p[6] = 64'hC000; m_len[6] = 48'h40; m_acc[6] = 4'h5;
    lookup(64'h6010, d);
    chk("collide_sees_write", {12'd0, d}, {12'd0, 4'h5, 48'h30, 64'hC010});

    // Flush during LOOKUP is deferred: current response still hits, next one misses
    cfg_write(3, 64'h9000, 64'hD000, 48'h100, 4'h6, 1'b1);
    start_lookup(64'h9010, 1'b1, e);
    chk("flush_mid_hit", {12'd0, resp_data}, {12'd0, 4'h6, 48'hF0, 64'hD010});
    finish_lookup();
    lookup(64'h9010, d);
    chk("flush_mid_after", {12'd0, d}, 128'd0);

    // Response held while table is rewritten and flushed
    cfg_write(0, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3, 1'b1);
    start_lookup(64'h1800, 1'b0, e);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        cfg_write(0, 64'h1800, 64'hDEAD_0000, 48'h10, 4'hF, 1'b1);
      end else begin
        if (c == 5) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        if (c == 5) model_flush();
      end
      chk("hold_valid", {127'd0, resp_valid}, 128'd1);
      chk("hold_data", {12'd0, resp_data}, {12'd0, e});
    end
    chk("hold_data_const", {12'd0, resp_data}, {12'd0, 4'h3, 48'h1800, 64'h8000_0800});
    finish_lookup();
    lookup(64'h1800, d);
    chk("after_hold_miss", {12'd0, d}, 128'd0);

    // Flush and cfg write together: flush wins
    cfg_write(4, 64'h7000, 64'hE000, 48'h100, 4'h7, 1'b1);
    flush      = 1'b1;
    cfg_valid  = 1'b1;
    cfg_idx    = 3'd4;
    cfg_en     = 1'b1;
    #1;
    chk("flush_cfg_ready", {127'd0, cfg_ready}, 128'd0);
    chk("flush_req_ready", {127'd0, req_ready}, 128'd0);
    @(posedge clk); #1;
    flush     = 1'b0;
    cfg_valid = 1'b0;
    model_flush();
    lookup(64'h7000, d);
    chk("flush_cfg_miss", {12'd0, d}, 128'd0);

    // Random table programming and lookups against the reference
    for (int it = 0; it < 30; it++) begin
      logic [47:0] rl;
      rl = ($urandom_range(0, 7) == 0) ? 48'd0 : 48'($urandom_range(1, 32'h3000));
      cfg_write(int'($urandom_range(0, N - 1)), 64'($urandom_range(0, 32'hF000)),
                {$urandom, $urandom}, rl, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 4) != 0));
      repeat (2) lookup(64'($urandom_range(0, 32'h1_3000)), d);
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
      end
    end

    // Reset in LOOKUP drops the lookup and the table
    cfg_write(0, 64'h1000, 64'h8000_0000, 48'h2000, 4'h3, 1'b1);
    req_valid = 1'b1;
    req_vaddr = 64'h1800;
    #1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 20) begin
      hs = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk("rst_lookup_hs", {127'd0, hs}, 128'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_valid", {127'd0, resp_valid}, 128'd0);
    chk("midrst_req_ready", {127'd0, req_ready}, 128'd0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    model_reset();
    repeat (4) begin
      @(posedge clk); #1;
      chk("postrst_no_resp", {127'd0, resp_valid}, 128'd0);
    end
    chk("postrst_hits", {96'd0, hit_cnt}, 128'd0);
    chk("postrst_miss", {96'd0, miss_cnt}, 128'd0);
    chk("postrst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("postrst_cfg_ready", {127'd0, cfg_ready}, 128'd1);
    lookup(64'h1800, d);
    chk("postrst_entry_gone", {12'd0, d}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roce_stack_addr_translator.md
ROCE_STACK_ADDR_TRANSLATOR -- requirements
Module: roce_stack_addr_translator

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8, number of translation entries (power of two, 2..64).
REQ-002 SHALL have clk_i  input  1  clock; all logic on rising edge.
REQ-003 SHALL have aresetn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_addr_valid_i  input  1; req_addr_ready_o  output  1; req_addr_vaddr_i  input  64  lookup virtual address.
REQ-005 SHALL have resp_addr_valid_o  output  1; resp_addr_ready_i  input  1; resp_addr_data_o  output  116  {accessdesc[3:0], buflen[47:0], paddr[63:0]}.
REQ-006 SHALL have cfg_wr_valid_i  input  1; cfg_wr_ready_o  output  1; cfg_idx_i  input  $clog2(NUM_ENTRIES)  entry index.
REQ-007 SHALL have cfg_vaddr_i  input  64, cfg_paddr_i  input  64, cfg_len_i  input  48, cfg_access_i  input  4, cfg_en_i  input  1  entry fields; cfg_en_i=0 invalidates the entry.
REQ-008 SHALL have flush_i  input  1  single-cycle pulse invalidating all entries.
REQ-009 SHALL have hit_cnt_o  output  32, miss_cnt_o  output  32  saturating lookup statistics.

Function
REQ-010 SHALL implement FSM IDLE, LOOKUP, RESP; reset state IDLE.
REQ-011 req_addr_ready_o SHALL be 1 only in IDLE and only when no cfg write or flush is applied that cycle.
REQ-012 IDLE: req handshake registers vaddr -> LOOKUP; LOOKUP: compare all entries, register result -> RESP (always one cycle); RESP: resp_addr_valid_o=1, data stable until resp_addr_ready_i=1 -> IDLE.
REQ-013 Latency SHALL be: request accepted at edge T, resp_addr_valid_o high from cycle T+2; throughput one lookup per 3 cycles minimum.
REQ-014 Entry i SHALL hit when valid, len!=0, and vaddr_i <= vaddr < vaddr_i + len_i, sum computed 65 bits wide (no wrap-around).
REQ-015 Multiple hits SHALL resolve to lowest index.
REQ-016 On hit, paddr SHALL be entry.paddr + (vaddr - entry.vaddr) mod 2^64, buflen SHALL be entry.len - (vaddr - entry.vaddr), accessdesc SHALL be entry.access.
REQ-017 On miss, resp_addr_data_o SHALL be all zero (accessdesc 4'h0 = no access).
REQ-018 cfg_wr_ready_o SHALL be 1 in IDLE and RESP, 0 in LOOKUP; write takes effect at handshake edge.
REQ-019 cfg write and req_addr_valid_i in same IDLE cycle: cfg write SHALL win; request stalls one cycle.
REQ-020 cfg write during RESP SHALL NOT alter the pending response.
REQ-021 flush_i in IDLE/RESP SHALL clear all valid bits at that edge; in LOOKUP it SHALL set a pending flag applied at the next edge; flush and cfg write same cycle: flush wins, cfg_wr_ready_o=0.
REQ-022 hit_cnt_o/miss_cnt_o SHALL increment once per lookup at LOOKUP exit and saturate at 32'hFFFF_FFFF.

Reset
REQ-023 aresetn_i low SHALL immediately force: state IDLE, all entries invalid, flush pending 0, counters 0, resp_addr_valid_o 0, resp_addr_data_o 0, req_addr_ready_o 0 while asserted.
REQ-024 Reset mid-LOOKUP or mid-RESP SHALL drop the in-flight lookup without any response after release.
REQ-025 Outputs after reset release: req_addr_ready_o 1, cfg_wr_ready_o 1.

Structure
REQ-026 roce_stack_pkg SHALL hold the translation response struct (116 bits, paddr at LSBs), entry struct, ACC_NONE=4'h0 and access-bit constants.
REQ-027 Per-entry range compare SHALL be sub-module roce_stack_xlat_match, instantiated NUM_ENTRIES times; priority encode in parent.
REQ-028 Table SHALL be flip-flops (no RAM), 180 bits per entry.

Verification
REQ-029 Write idx0 {v=0x1000, p=0x8000_0000, len=0x2000, acc=4'h3}; lookup 0x1800 -> at T+2 paddr 0x8000_0800, buflen 0x1800, acc 3; hit_cnt 1.
REQ-030 Lookup 0x3000 (end boundary) and 0x0FFF -> both all-zero data, miss_cnt 2; 0x2FFF hits with buflen 1.
REQ-031 idx1 and idx5 both cover 0x4000 -> idx1 fields returned; invalidate idx1 (cfg_en_i=0) -> idx5 returned.
REQ-032 Entry v=0xFFFF_FFFF_FFFF_F000, len=0x2000: lookup 0xFFFF_FFFF_FFFF_FFF0 hits, lookup 0x0 misses.
REQ-033 Hold resp_addr_ready_i=0 for 10 cycles while writing the hitting entry and pulsing flush_i -> response data unchanged; next lookup misses.
REQ-034 Assert aresetn_i in LOOKUP -> after release no resp_addr_valid_o, counters 0, prior entries miss.
